// File: rtl/ycfsm_seq.sv
// ycfsm_seq: synchronous request/response controller for one asynchronous
// ycfsm cell. It injects a dual-rail token, waits for the cell to answer
// and then to return to empty, and reports the captured value to the host.
// Optional feature macro: YCFSM_SEQ_TIMEOUT_EN adds a per-phase wait timeout
// in DRIVE and RELEASE. Without it the controller waits indefinitely.
module ycfsm_seq #(
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_bit,
    input  logic [1:0] req_match,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [1:0] rsp_value,
    output logic       rsp_err,
    output logic       cell_reset,
    output logic [1:0] cell_in,
    output logic [1:0] cell_match,
    input  logic [1:0] cell_out
);

    localparam logic [2:0] ST_RST_HOLD = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_DRIVE    = 3'd2;
    localparam logic [2:0] ST_RELEASE  = 3'd3;
    localparam logic [2:0] ST_RESP     = 3'd4;

    localparam int            RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

    // Reject parameter values the counters cannot represent.
    if (RST_CYCLES < 1 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
        $error("ycfsm_seq: RST_CYCLES must be >= 1 and TIMEOUT in 1..65535");
    end

    logic [2:0]    state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [1:0]    sync_q, s_out_q, s_prev_q;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [1:0]    rsp_value_q, rsp_value_d;
    logic          rsp_err_q, rsp_err_d;
    logic          cell_reset_q, cell_reset_d;
    logic [1:0]    cell_in_q, cell_in_d;
    logic [1:0]    cell_match_q, cell_match_d;
    logic          stable;

`ifdef YCFSM_SEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] phase_cnt_q, phase_cnt_d;
    logic        timeout_hit;
    assign timeout_hit = (phase_cnt_q >= TO_LAST);
`endif

    // The synchronized code counts as settled once it repeats on two cycles.
    assign stable = (s_out_q == s_prev_q);

    // Two-flop synchronizer on the asynchronous cell output, plus one history stage.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples the pre-edge value, which is what makes the chain a chain.
        if (reset) begin
            sync_q   <= 2'b00;
            s_out_q  <= 2'b00;
            s_prev_q <= 2'b00;
        end else begin
            sync_q   <= cell_out;
            s_out_q  <= sync_q;
            s_prev_q <= s_out_q;
        end
    end

    // Next-state and registered-output logic of the handshake sequencer.
    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        req_ready_d  = req_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_value_d  = rsp_value_q;
        rsp_err_d    = rsp_err_q;
        cell_reset_d = cell_reset_q;
        cell_in_d    = cell_in_q;
        cell_match_d = cell_match_q;
`ifdef YCFSM_SEQ_TIMEOUT_EN
        phase_cnt_d  = phase_cnt_q;
`endif
        case (state_q)
            ST_RST_HOLD: begin
                if (rst_cnt_q == RST_LAST) begin
                    rst_cnt_d    = '0;
                    cell_reset_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d  = 1'b0;
                    cell_in_d    = {req_bit, ~req_bit};
                    cell_match_d = req_match;
                    state_d      = ST_DRIVE;
`ifdef YCFSM_SEQ_TIMEOUT_EN
                    phase_cnt_d  = '0;
`endif
                end
            end
            ST_DRIVE: begin
`ifdef YCFSM_SEQ_TIMEOUT_EN
                if (phase_cnt_q != 16'hFFFF) phase_cnt_d = phase_cnt_q + 16'd1;
`endif
                if (stable && (s_out_q == 2'b01 || s_out_q == 2'b10)) begin
                    rsp_value_d = s_out_q;
                    cell_in_d   = 2'b00;
                    state_d     = ST_RELEASE;
`ifdef YCFSM_SEQ_TIMEOUT_EN
                    phase_cnt_d = '0;
`endif
                end else if (stable && s_out_q == 2'b11) begin
                    rsp_value_d = 2'b11;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    cell_in_d   = 2'b00;
                    state_d     = ST_RESP;
                end
`ifdef YCFSM_SEQ_TIMEOUT_EN
                else if (timeout_hit) begin
                    rsp_value_d = s_out_q;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    cell_in_d   = 2'b00;
                    state_d     = ST_RESP;
                end
`endif
            end
            ST_RELEASE: begin
`ifdef YCFSM_SEQ_TIMEOUT_EN
                if (phase_cnt_q != 16'hFFFF) phase_cnt_d = phase_cnt_q + 16'd1;
`endif
                if (stable && s_out_q == 2'b00) begin
                    cell_match_d = 2'b00;
                    rsp_err_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end
`ifdef YCFSM_SEQ_TIMEOUT_EN
                else if (timeout_hit) begin
                    rsp_value_d = s_out_q;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_err_q) begin
                        // An error leaves the cell in an unknown state: reset it.
                        cell_reset_d = 1'b1;
                        cell_in_d    = 2'b00;
                        cell_match_d = 2'b00;
                        rst_cnt_d    = '0;
                        state_d      = ST_RST_HOLD;
                    end else begin
                        req_ready_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: begin
                cell_reset_d = 1'b1;
                cell_in_d    = 2'b00;
                cell_match_d = 2'b00;
                req_ready_d  = 1'b0;
                rsp_valid_d  = 1'b0;
                rst_cnt_d    = '0;
                state_d      = ST_RST_HOLD;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RST_HOLD;
            rst_cnt_q    <= '0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_value_q  <= 2'b00;
            rsp_err_q    <= 1'b0;
            cell_reset_q <= 1'b1;
            cell_in_q    <= 2'b00;
            cell_match_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_value_q  <= rsp_value_d;
            rsp_err_q    <= rsp_err_d;
            cell_reset_q <= cell_reset_d;
            cell_in_q    <= cell_in_d;
            cell_match_q <= cell_match_d;
        end
    end

`ifdef YCFSM_SEQ_TIMEOUT_EN
    // Per-phase wait counter, cleared when DRIVE or RELEASE is entered.
    always_ff @(posedge clk) begin
        if (reset) phase_cnt_q <= '0;
        else       phase_cnt_q <= phase_cnt_d;
    end
`endif

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_value  = rsp_value_q;
    assign rsp_err    = rsp_err_q;
    assign cell_reset = cell_reset_q;
    assign cell_in    = cell_in_q;
    assign cell_match = cell_match_q;

endmodule
